cdb_broadcast_arbiter: RTL and testbench

Transmitter side of the common data bus. Collects completed results from the four execution sources (ALU, branch unit, load/store unit, multiplier), buffers each source in a small FIFO, and selects one result per cycle to drive onto the bus. The reorder buffer, commit stage and reservation stations all receive this broadcast. The block also applies pipeline flushes to its buffered results on a misprediction.

---
 rtl/cdb_pkg.sv | 19 +
 rtl/cdb_broadcast_arbiter_if.sv | 33 +++
 rtl/cdb_source_fifo.sv | 57 +++++
 rtl/cdb_broadcast_arbiter.sv | 134 +++++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared packet type and source indices for the CDB transmitter
package cdb_pkg;

  localparam int CDB_WIDTH = 31;
  localparam int CDB_ROB   = 2;

  localparam int SRC_ALU    = 0;
  localparam int SRC_BRANCH = 1;
  localparam int SRC_MEM    = 2;
  localparam int SRC_MUL    = 3;

  typedef struct packed {
    logic [CDB_ROB:0]   tag;
    logic [CDB_WIDTH:0] result;
    logic [CDB_WIDTH:0] target;
    logic               mispredict;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_broadcast_arbiter_if.sv
// rtl/cdb_broadcast_arbiter_if.sv - source-side and bus-side signals of the CDB transmitter
interface cdb_broadcast_arbiter_if #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int SRC   = 4
);
  import cdb_pkg::*;

  logic [SRC-1:0]            srcValid;
  logic [SRC-1:0]            srcReady;
  logic [SRC-1:0][ROB:0]     srcTag;
  logic [SRC-1:0][WIDTH:0]   srcResult;
  logic [SRC-1:0][WIDTH:0]   srcTarget;
  logic [SRC-1:0]            srcMispredict;

  logic                      cdbValid;
  logic [ROB:0]              cdbTag;
  logic [WIDTH:0]            cdbResult;
  logic [WIDTH:0]            cdbTarget;
  logic                      cdbMispredict;
  logic [1:0]                cdbSource;

  modport slave (
    input  srcValid, srcTag, srcResult, srcTarget, srcMispredict,
    output srcReady, cdbValid, cdbTag, cdbResult, cdbTarget, cdbMispredict, cdbSource
  );

  modport master (
    output srcValid, srcTag, srcResult, srcTarget, srcMispredict,
    input  srcReady, cdbValid, cdbTag, cdbResult, cdbTarget, cdbMispredict, cdbSource
  );

endinterface

// File: rtl/cdb_source_fifo.sv
// rtl/cdb_source_fifo.sv - per-source result FIFO with push/pop/flush
module cdb_source_fifo
  import cdb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  cdb_packet_t       push_data,
  output cdb_packet_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  cdb_packet_t          mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && (count < CNT_W'(DEPTH)) && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// rtl/cdb_broadcast_arbiter.sv - round-robin CDB transmitter over per-source FIFOs
// Optional CDB_BRANCH_PRIORITY_EN: branch source wins whenever non-empty.
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int SRC   = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  cdb_broadcast_arbiter_if.slave   bus
);

  localparam int RR_W  = (SRC > 1) ? $clog2(SRC) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   grant_idx;
  logic [RR_W-1:0]   cand;
  logic              grant_found;
  logic              grant;
  logic              hold_rr;
  logic              ready_en;
  logic [SRC-1:0]    empty;
  logic [SRC-1:0]    push;
  logic [SRC-1:0]    pop;
  logic [SRC-1:0]    ready_vec;
  logic [CNT_W-1:0]  count [SRC];
  cdb_packet_t       head [SRC];
  cdb_packet_t       in_pkt [SRC];

  logic              valid_q;
  logic [ROB:0]      tag_q;
  logic [WIDTH:0]    result_q;
  logic [WIDTH:0]    target_q;
  logic              mispredict_q;
  logic [1:0]        source_q;

  // ready_en keeps srcReady low through reset without a comb path from the reset pin
  always_comb begin
    ready_vec = '0;
    push      = '0;
    pop       = '0;
    for (int i = 0; i < SRC; i++) begin
      ready_vec[i] = ready_en && (count[i] < CNT_W'(DEPTH));
      push[i]      = bus.srcValid[i] && ready_vec[i];
      pop[i]       = grant && (grant_idx == RR_W'(i));
      in_pkt[i]    = '{tag: bus.srcTag[i], result: bus.srcResult[i],
                       target: bus.srcTarget[i], mispredict: bus.srcMispredict[i]};
    end
  end

  assign bus.srcReady = ready_vec;

  for (genvar g = 0; g < SRC; g++) begin : g_fifo
    cdb_source_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (in_pkt[g]),
      .head      (head[g]),
      .count     (count[g]),
      .empty     (empty[g])
    );
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    hold_rr     = 1'b0;
`ifdef CDB_BRANCH_PRIORITY_EN
    if (!empty[SRC_BRANCH]) begin
      grant_found = 1'b1;
      grant_idx   = RR_W'(SRC_BRANCH);
      hold_rr     = 1'b1;
    end
`endif
    for (int off = 0; off < SRC; off++) begin
      cand = RR_W'((int'(rr_ptr) + off) % SRC);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant = grant_found && !flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      ready_en     <= 1'b0;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      result_q     <= '0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      source_q     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (grant && !hold_rr) begin
        rr_ptr <= (grant_idx == RR_W'(SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (grant) begin
        valid_q      <= 1'b1;
        tag_q        <= head[grant_idx].tag;
        result_q     <= head[grant_idx].result;
        target_q     <= head[grant_idx].target;
        mispredict_q <= head[grant_idx].mispredict;
        source_q     <= 2'(grant_idx);
      end else begin
        valid_q      <= 1'b0;
        tag_q        <= '0;
        result_q     <= '0;
        target_q     <= '0;
        mispredict_q <= 1'b0;
        source_q     <= '0;
      end
    end
  end

  assign bus.cdbValid      = valid_q;
  assign bus.cdbTag        = tag_q;
  assign bus.cdbResult     = result_q;
  assign bus.cdbTarget     = target_q;
  assign bus.cdbMispredict = mispredict_q;
  assign bus.cdbSource     = source_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb/tb_cdb_broadcast_arbiter.sv - directed bench for cdb_broadcast_arbiter
// Expectations switch on CDB_BRANCH_PRIORITY_EN where grant order differs.
module tb_cdb_broadcast_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_broadcast_arbiter_if bus ();

  cdb_broadcast_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.srcValid      = '0;
    bus.srcTag        = '0;
    bus.srcResult     = '0;
    bus.srcTarget     = '0;
    bus.srcMispredict = '0;
  endtask

  task automatic drive(input int s, input logic [2:0] tag, input logic [31:0] res,
                       input logic [31:0] tgt, input logic mis);
    bus.srcValid[s]      = 1'b1;
    bus.srcTag[s]        = tag;
    bus.srcResult[s]     = res;
    bus.srcTarget[s]     = tgt;
    bus.srcMispredict[s] = mis;
  endtask

  task automatic expect_cdb(input string name, input logic v, input logic [2:0] tag,
                            input logic [31:0] res, input logic [1:0] src);
    check({name, ".valid"},  bus.cdbValid,  v);
    check({name, ".tag"},    bus.cdbTag,    tag);
    check({name, ".result"}, bus.cdbResult, res);
    check({name, ".source"}, bus.cdbSource, src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] seq [2];
  logic [31:0] exp_seq [2];
  logic [3:0]  rdy;
  int          exp_s;

  initial begin
    idle();
    // reset state
    tick(); tick();
    check("rst.ready", bus.srcReady, 4'h0);
    expect_cdb("rst", 1'b0, 3'd0, 32'h0, 2'd0);
    reset = 1'b0;
    tick();
    check("post_rst.ready", bus.srcReady, 4'hF);

    // single packet, two-cycle latency
    drive(0, 3'd3, 32'h42, 32'h0, 1'b0);
    tick(); idle();
    check("lat.c2.valid", bus.cdbValid, 1'b0);
    tick();
    expect_cdb("lat.c3", 1'b1, 3'd3, 32'h42, 2'd0);
    tick();
    expect_cdb("lat.c4", 1'b0, 3'd0, 32'h0, 2'd0);

    // all four at once from rr_ptr=0
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int s = 0; s < 4; s++) drive(s, 3'(4 + s), 32'h100 + 32'(s), 32'h0, 1'b0);
    tick(); idle();
    check("all4.c1.valid", bus.cdbValid, 1'b0);
    begin
      int order [4];
`ifdef CDB_BRANCH_PRIORITY_EN
      order = '{1, 0, 2, 3};
`else
      order = '{0, 1, 2, 3};
`endif
      for (int k = 0; k < 4; k++) begin
        tick();
        expect_cdb($sformatf("all4.g%0d", k), 1'b1, 3'(4 + order[k]),
                   32'h100 + 32'(order[k]), 2'(order[k]));
      end
    end
    tick();
    check("all4.end.valid", bus.cdbValid, 1'b0);

    // source 2 overruns its FIFO while others hold the bus
    drive(0, 3'd0, 32'h10, 32'h0, 1'b0);
    drive(1, 3'd1, 32'h11, 32'h0, 1'b0);
    drive(2, 3'd2, 32'h21, 32'h0, 1'b0);
    tick();
    check("bp.c1.valid", bus.cdbValid, 1'b0);
    bus.srcValid[0] = 1'b0;
    bus.srcValid[1] = 1'b0;
    drive(2, 3'd3, 32'h22, 32'h0, 1'b0);
    tick();
    check("bp.c2.ready", bus.srcReady, 4'b1011);
`ifdef CDB_BRANCH_PRIORITY_EN
    expect_cdb("bp.c2", 1'b1, 3'd1, 32'h11, 2'd1);
`else
    expect_cdb("bp.c2", 1'b1, 3'd0, 32'h10, 2'd0);
`endif
    drive(2, 3'd4, 32'h23, 32'h0, 1'b0);
    tick();
    check("bp.c3.ready", bus.srcReady, 4'b1011);
`ifdef CDB_BRANCH_PRIORITY_EN
    expect_cdb("bp.c3", 1'b1, 3'd0, 32'h10, 2'd0);
`else
    expect_cdb("bp.c3", 1'b1, 3'd1, 32'h11, 2'd1);
`endif
    tick();
    check("bp.c4.ready", bus.srcReady, 4'hF);
    expect_cdb("bp.c4", 1'b1, 3'd2, 32'h21, 2'd2);
    tick(); idle();
    expect_cdb("bp.c5", 1'b1, 3'd3, 32'h22, 2'd2);
    tick();
    expect_cdb("bp.c6", 1'b1, 3'd4, 32'h23, 2'd2);
    tick();
    check("bp.c7.valid", bus.cdbValid, 1'b0);

    // mispredict broadcast, then flush with three packets buffered
    drive(1, 3'd5, 32'h55, 32'h100, 1'b1);
    tick(); idle();
    check("mp.c1.valid", bus.cdbValid, 1'b0);
    tick();
    expect_cdb("mp.c2", 1'b1, 3'd5, 32'h55, 2'd1);
    check("mp.c2.mispredict", bus.cdbMispredict, 1'b1);
    check("mp.c2.target", bus.cdbTarget, 32'h100);
    tick();
    check("mp.c3.mispredict", bus.cdbMispredict, 1'b0);
    check("mp.c3.target", bus.cdbTarget, 32'h0);
    drive(0, 3'd1, 32'hF1, 32'h0, 1'b0);
    drive(2, 3'd2, 32'hF2, 32'h0, 1'b0);
    drive(3, 3'd3, 32'hF3, 32'h0, 1'b0);
    tick(); idle();
    flush = 1'b1;
    drive(0, 3'd7, 32'hF7, 32'h0, 1'b0);
    check("fl.c4.valid", bus.cdbValid, 1'b0);
    tick(); idle();
    flush = 1'b0;
    check("fl.c5.valid", bus.cdbValid, 1'b0);
    check("fl.c5.ready", bus.srcReady, 4'hF);
    tick();
    check("fl.c6.valid", bus.cdbValid, 1'b0);
    tick();
    check("fl.c7.valid", bus.cdbValid, 1'b0);

    // sources 0 and 1 continuously non-empty
    for (int s = 0; s < 2; s++) begin
      seq[s] = 0;
      exp_seq[s] = 0;
      drive(s, 3'(s), (32'(s) << 16) | seq[s], 32'h0, 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      rdy = bus.srcReady;
      tick();
      for (int s = 0; s < 2; s++) begin
        if (rdy[s]) seq[s] = seq[s] + 1;
        bus.srcResult[s] = (32'(s) << 16) | seq[s];
      end
      if (k == 1) begin
        check("cont.k1.valid", bus.cdbValid, 1'b0);
      end else begin
`ifdef CDB_BRANCH_PRIORITY_EN
        exp_s = 1;
`else
        exp_s = (k % 2 == 0) ? 0 : 1;
`endif
        check($sformatf("cont.k%0d.valid", k), bus.cdbValid, 1'b1);
        check($sformatf("cont.k%0d.source", k), bus.cdbSource, 2'(exp_s));
        check($sformatf("cont.k%0d.result", k), bus.cdbResult,
              (32'(exp_s) << 16) | exp_seq[exp_s]);
        exp_seq[exp_s] = exp_seq[exp_s] + 1;
      end
    end

    // reset mid-stream with FIFOs non-empty
    idle();
    reset = 1'b1;
    tick();
    expect_cdb("mrst", 1'b0, 3'd0, 32'h0, 2'd0);
    check("mrst.ready", bus.srcReady, 4'h0);
    reset = 1'b0;
    tick();
    check("mrst.r1.ready", bus.srcReady, 4'hF);
    check("mrst.r1.valid", bus.cdbValid, 1'b0);
    drive(0, 3'd2, 32'hA0, 32'h0, 1'b0);
    drive(3, 3'd6, 32'hA3, 32'h0, 1'b0);
    tick(); idle();
    check("mrst.r2.valid", bus.cdbValid, 1'b0);
    tick();
    expect_cdb("mrst.r3", 1'b1, 3'd2, 32'hA0, 2'd0);
    tick();
    expect_cdb("mrst.r4", 1'b1, 3'd6, 32'hA3, 2'd3);
    tick();
    check("mrst.r5.valid", bus.cdbValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
